zap_top_core: RTL and testbench

Minimal multicycle 32-bit ARM-subset processor (ARMv4 A32 encoding) with separate Wishbone B3 classic master ports for instruction and data. It fetches, executes and performs data access one instruction at a time, with no pipeline overlap. It sits at the top of the CPU hierarchy, between the system clock/reset and a dual-port Wishbone memory. There is no cache, no MMU, no prefetch FIFO and no branch predictor. The cache/MMU parameters are accepted only for integration compatibility.

---
 rtl/zap_top_core.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_zap_top_core.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/zap_top_core.sv
`default_nettype none
// ============================================================================
// Module  : zap_top_core
// Brief   : Multicycle ARMv4 A32-subset core with separate Wishbone I/D masters
// Revision: 1.0
// ============================================================================
module zap_top_core #(
  parameter int CACHE_MMU_ENABLE         = 0,
  parameter int FIFO_DEPTH               = 4,
  parameter int BP_ENTRIES               = 1024,
  parameter int DATA_SECTION_TLB_ENTRIES = 4,
  parameter int DATA_LPAGE_TLB_ENTRIES   = 8,
  parameter int DATA_SPAGE_TLB_ENTRIES   = 16,
  parameter int DATA_CACHE_SIZE          = 1024,
  parameter int CODE_SECTION_TLB_ENTRIES = 4,
  parameter int CODE_LPAGE_TLB_ENTRIES   = 8,
  parameter int CODE_SPAGE_TLB_ENTRIES   = 16,
  parameter int CODE_CACHE_SIZE          = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_irq,
  input  logic        i_fiq,
  output logic        o_instr_wb_cyc,
  output logic        o_instr_wb_stb,
  output logic [31:0] o_instr_wb_adr,
  output logic        o_instr_wb_we,
  output logic [3:0]  o_instr_wb_sel,
  input  logic [31:0] i_instr_wb_dat,
  input  logic        i_instr_wb_ack,
  input  logic        i_instr_wb_err,
  output logic        o_data_wb_cyc,
  output logic        o_data_wb_stb,
  output logic        o_data_wb_we,
  output logic [31:0] o_data_wb_adr,
  output logic [3:0]  o_data_wb_sel,
  output logic [31:0] o_data_wb_dat,
  input  logic [31:0] i_data_wb_dat,
  input  logic        i_data_wb_ack,
  input  logic        i_data_wb_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2
  } state_t;

  localparam logic [31:0] c_nop_instr = 32'hE1A0_0000;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] regs_q [16];
  logic [3:0]  flags_q;  // {N, Z, C, V}

  logic        iwb_cyc_q, iwb_stb_q;
  logic [31:0] iwb_adr_q;
  logic [3:0]  iwb_sel_q;
  logic        dwb_cyc_q, dwb_stb_q, dwb_we_q;
  logic [31:0] dwb_adr_q, dwb_dat_q;
  logic [3:0]  dwb_sel_q;

  logic        ls_load_q, ls_byte_q, ls_wb_q;
  logic [3:0]  ls_rd_q, ls_rn_q;
  logic [1:0]  ls_lane_q;
  logic [31:0] ls_wbval_q;

  logic        f_n, f_z, f_c, f_v;
  assign {f_n, f_z, f_c, f_v} = flags_q;

  logic [31:0] rn_val, rm_val, rd_val;
  logic        cond_pass;
  logic [4:0]  sh_amt, sh_inv, sh_m1, rot2;
  logic [31:0] sh_res, imm_val, imm_res, op2;
  logic        sh_c, op2_c;
  logic [31:0] add_a, add_b, logic_res, dp_res;
  logic        add_cin, is_arith, ovf;
  logic [32:0] sum;
  logic        is_dp, is_ls, is_br, dp_writes;
  logic [3:0]  opc;
  logic [31:0] ls_off, ls_addr_off, ls_eff, br_target, ld_val;
  logic [3:0]  flags_d;

  assign rn_val = (ir_q[19:16] == 4'd15) ? pc_q + 32'd8 : regs_q[ir_q[19:16]];
  assign rm_val = (ir_q[3:0]   == 4'd15) ? pc_q + 32'd8 : regs_q[ir_q[3:0]];
  assign rd_val = (ir_q[15:12] == 4'd15) ? pc_q + 32'd8 : regs_q[ir_q[15:12]];
  assign opc    = ir_q[24:21];

  // PSR transfers (10xx with S clear) and register-shifted/multiply forms are not data processing here
  assign is_dp = (ir_q[27:26] == 2'b00) && !(ir_q[24:23] == 2'b10 && !ir_q[20])
                 && (ir_q[25] || !ir_q[4]);
  assign is_ls = (ir_q[27:25] == 3'b010);
  assign is_br = (ir_q[27:25] == 3'b101);
  assign dp_writes = (opc[3:2] != 2'b10);

  always_comb begin
    case (ir_q[31:28])
      4'd0:    cond_pass = f_z;
      4'd1:    cond_pass = !f_z;
      4'd2:    cond_pass = f_c;
      4'd3:    cond_pass = !f_c;
      4'd4:    cond_pass = f_n;
      4'd5:    cond_pass = !f_n;
      4'd6:    cond_pass = f_v;
      4'd7:    cond_pass = !f_v;
      4'd8:    cond_pass = f_c && !f_z;
      4'd9:    cond_pass = !f_c || f_z;
      4'd10:   cond_pass = (f_n == f_v);
      4'd11:   cond_pass = (f_n != f_v);
      4'd12:   cond_pass = !f_z && (f_n == f_v);
      4'd13:   cond_pass = f_z || (f_n != f_v);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Barrel shifter; an amount of 0 selects the LSR/ASR #32 and RRX encodings
  always_comb begin
    sh_amt = ir_q[11:7];
    sh_inv = 5'd0 - sh_amt;
    sh_m1  = sh_amt - 5'd1;
    sh_res = rm_val;
    sh_c   = f_c;
    case (ir_q[6:5])
      2'b00: begin
        if (sh_amt != 5'd0) begin
          sh_res = rm_val << sh_amt;
          sh_c   = rm_val[sh_inv];
        end
      end
      2'b01: begin
        if (sh_amt == 5'd0) begin
          sh_res = 32'd0;
          sh_c   = rm_val[31];
        end else begin
          sh_res = rm_val >> sh_amt;
          sh_c   = rm_val[sh_m1];
        end
      end
      2'b10: begin
        if (sh_amt == 5'd0) begin
          sh_res = {32{rm_val[31]}};
          sh_c   = rm_val[31];
        end else begin
          sh_res = $unsigned($signed(rm_val) >>> sh_amt);
          sh_c   = rm_val[sh_m1];
        end
      end
      default: begin
        if (sh_amt == 5'd0) begin
          sh_res = {f_c, rm_val[31:1]};
          sh_c   = rm_val[0];
        end else begin
          sh_res = (rm_val >> sh_amt) | (rm_val << sh_inv);
          sh_c   = rm_val[sh_m1];
        end
      end
    endcase
  end

  always_comb begin
    rot2    = {ir_q[11:8], 1'b0};
    imm_val = {24'd0, ir_q[7:0]};
    imm_res = (rot2 == 5'd0) ? imm_val : ((imm_val >> rot2) | (imm_val << (5'd0 - rot2)));
    op2     = ir_q[25] ? imm_res : sh_res;
    op2_c   = ir_q[25] ? ((rot2 == 5'd0) ? f_c : imm_res[31]) : sh_c;
  end

  always_comb begin
    add_a    = rn_val;
    add_b    = op2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (opc)
      4'd2, 4'd10: begin add_b = ~op2; add_cin = 1'b1; end
      4'd3:        begin add_a = op2; add_b = ~rn_val; add_cin = 1'b1; end
      4'd4, 4'd11: add_cin = 1'b0;
      4'd5:        add_cin = f_c;
      4'd6:        begin add_b = ~op2; add_cin = f_c; end
      4'd7:        begin add_a = op2; add_b = ~rn_val; add_cin = f_c; end
      default:     is_arith = 1'b0;
    endcase
    sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    ovf = (add_a[31] == add_b[31]) && (sum[31] != add_a[31]);

    case (opc)
      4'd0, 4'd8:  logic_res = rn_val & op2;
      4'd1, 4'd9:  logic_res = rn_val ^ op2;
      4'd12:       logic_res = rn_val | op2;
      4'd13:       logic_res = op2;
      4'd14:       logic_res = rn_val & ~op2;
      default:     logic_res = ~op2;
    endcase
    dp_res  = is_arith ? sum[31:0] : logic_res;
    flags_d = {dp_res[31], (dp_res == 32'd0), (is_arith ? sum[32] : op2_c),
               (is_arith ? ovf : f_v)};
  end

  always_comb begin
    ls_off      = {20'd0, ir_q[11:0]};
    ls_addr_off = ir_q[23] ? rn_val + ls_off : rn_val - ls_off;
    ls_eff      = ir_q[24] ? ls_addr_off : rn_val;
    br_target   = pc_q + 32'd8 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
    case (ls_lane_q)
      2'd0:    ld_val = {24'd0, i_data_wb_dat[7:0]};
      2'd1:    ld_val = {24'd0, i_data_wb_dat[15:8]};
      2'd2:    ld_val = {24'd0, i_data_wb_dat[23:16]};
      default: ld_val = {24'd0, i_data_wb_dat[31:24]};
    endcase
    if (!ls_byte_q) ld_val = i_data_wb_dat;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_FETCH;
      pc_q       <= 32'd0;
      ir_q       <= c_nop_instr;
      flags_q    <= 4'd0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 32'd0;
      iwb_cyc_q  <= 1'b0;
      iwb_stb_q  <= 1'b0;
      iwb_adr_q  <= 32'd0;
      iwb_sel_q  <= 4'd0;
      dwb_cyc_q  <= 1'b0;
      dwb_stb_q  <= 1'b0;
      dwb_we_q   <= 1'b0;
      dwb_adr_q  <= 32'd0;
      dwb_sel_q  <= 4'd0;
      dwb_dat_q  <= 32'd0;
      ls_load_q  <= 1'b0;
      ls_byte_q  <= 1'b0;
      ls_wb_q    <= 1'b0;
      ls_rd_q    <= 4'd0;
      ls_rn_q    <= 4'd0;
      ls_lane_q  <= 2'd0;
      ls_wbval_q <= 32'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!iwb_cyc_q) begin
            iwb_cyc_q <= 1'b1;
            iwb_stb_q <= 1'b1;
            iwb_adr_q <= {pc_q[31:2], 2'b00};
            iwb_sel_q <= 4'hF;
          end else if (i_instr_wb_ack || i_instr_wb_err) begin
            ir_q      <= i_instr_wb_err ? c_nop_instr : i_instr_wb_dat;
            iwb_cyc_q <= 1'b0;
            iwb_stb_q <= 1'b0;
            iwb_sel_q <= 4'd0;
            state_q   <= S_EXEC;
          end
        end

        S_EXEC: begin
          state_q <= S_FETCH;
          if (!cond_pass) begin
            pc_q <= pc_q + 32'd4;
          end else if (is_dp) begin
            if (ir_q[20]) flags_q <= flags_d;
            if (dp_writes && ir_q[15:12] == 4'd15) begin
              pc_q <= dp_res & ~32'd3;
            end else begin
              if (dp_writes) regs_q[ir_q[15:12]] <= dp_res;
              pc_q <= pc_q + 32'd4;
            end
          end else if (is_ls) begin
            dwb_cyc_q  <= 1'b1;
            dwb_stb_q  <= 1'b1;
            dwb_we_q   <= !ir_q[20];
            if (ir_q[22]) begin
              dwb_adr_q <= ls_eff;
              dwb_sel_q <= 4'b0001 << ls_eff[1:0];
              dwb_dat_q <= {4{rd_val[7:0]}};
            end else begin
              dwb_adr_q <= {ls_eff[31:2], 2'b00};
              dwb_sel_q <= 4'hF;
              dwb_dat_q <= rd_val;
            end
            ls_load_q  <= ir_q[20];
            ls_byte_q  <= ir_q[22];
            ls_wb_q    <= !ir_q[24] || ir_q[21];
            ls_rd_q    <= ir_q[15:12];
            ls_rn_q    <= ir_q[19:16];
            ls_lane_q  <= ls_eff[1:0];
            ls_wbval_q <= ls_addr_off;
            state_q    <= S_MEM;
          end else if (is_br) begin
            if (ir_q[24]) regs_q[14] <= pc_q + 32'd4;
            pc_q <= br_target;
          end else begin
            pc_q <= pc_q + 32'd4;
          end
        end

        S_MEM: begin
          if (i_data_wb_ack || i_data_wb_err) begin
            dwb_cyc_q <= 1'b0;
            dwb_stb_q <= 1'b0;
            dwb_we_q  <= 1'b0;
            dwb_sel_q <= 4'd0;
            dwb_adr_q <= 32'd0;
            dwb_dat_q <= 32'd0;
            // Base first so that a load into the base register overrides it
            if (ls_wb_q && ls_rn_q != 4'd15) regs_q[ls_rn_q] <= ls_wbval_q;
            if (ls_load_q && i_data_wb_ack && !i_data_wb_err && ls_rd_q == 4'd15) begin
              pc_q <= ld_val & ~32'd3;
            end else begin
              if (ls_load_q && i_data_wb_ack && !i_data_wb_err) regs_q[ls_rd_q] <= ld_val;
              pc_q <= pc_q + 32'd4;
            end
            state_q <= S_FETCH;
          end
        end

        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign o_instr_wb_cyc = iwb_cyc_q;
  assign o_instr_wb_stb = iwb_stb_q;
  assign o_instr_wb_adr = iwb_adr_q;
  assign o_instr_wb_we  = 1'b0;
  assign o_instr_wb_sel = iwb_sel_q;
  assign o_data_wb_cyc  = dwb_cyc_q;
  assign o_data_wb_stb  = dwb_stb_q;
  assign o_data_wb_we   = dwb_we_q;
  assign o_data_wb_adr  = dwb_adr_q;
  assign o_data_wb_sel  = dwb_sel_q;
  assign o_data_wb_dat  = dwb_dat_q;

  // Interrupts are permanently masked; cache/MMU sizing is integration-only
  logic unused_ok;
  assign unused_ok = ^{i_irq, i_fiq, CACHE_MMU_ENABLE, FIFO_DEPTH, BP_ENTRIES,
                       DATA_SECTION_TLB_ENTRIES, DATA_LPAGE_TLB_ENTRIES,
                       DATA_SPAGE_TLB_ENTRIES, DATA_CACHE_SIZE,
                       CODE_SECTION_TLB_ENTRIES, CODE_LPAGE_TLB_ENTRIES,
                       CODE_SPAGE_TLB_ENTRIES, CODE_CACHE_SIZE};

endmodule
`default_nettype wire

// File: tb/tb_zap_top_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_zap_top_core
// Brief   : Directed program vectors for zap_top_core against a dual-port memory
// Revision: 1.0
// ============================================================================
module tb_zap_top_core;

  localparam logic [31:0] HALT = 32'hEAFF_FFFE;  // B .

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        icyc, istb, iwe, dcyc, dstb, dwe;
  logic [31:0] iadr, dadr, dwdat;
  logic [3:0]  isel, dsel;
  logic        iack, dack;
  logic [31:0] idat, drdat;

  zap_top_core dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_irq          (1'b0),
    .i_fiq          (1'b0),
    .o_instr_wb_cyc (icyc),
    .o_instr_wb_stb (istb),
    .o_instr_wb_adr (iadr),
    .o_instr_wb_we  (iwe),
    .o_instr_wb_sel (isel),
    .i_instr_wb_dat (idat),
    .i_instr_wb_ack (iack),
    .i_instr_wb_err (1'b0),
    .o_data_wb_cyc  (dcyc),
    .o_data_wb_stb  (dstb),
    .o_data_wb_we   (dwe),
    .o_data_wb_adr  (dadr),
    .o_data_wb_sel  (dsel),
    .o_data_wb_dat  (dwdat),
    .i_data_wb_dat  (drdat),
    .i_data_wb_ack  (dack),
    .i_data_wb_err  (1'b0)
  );

  logic [31:0] img [0:1023];
  logic [31:0] mem [0:1023];
  int          max_stall = 0;
  bit          hold_dack = 1'b0;
  int          istall, dstall;
  logic [3:0]  bw_sel;
  logic [31:0] bw_dat;
  int          both_cyc = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
      iack <= 1'b0; dack <= 1'b0; istall <= 0; dstall <= 0;
      idat <= 32'd0; drdat <= 32'd0;
    end else begin
      iack <= 1'b0;
      dack <= 1'b0;
      if (icyc && istb && !iack) begin
        if (istall == 0) begin
          iack   <= 1'b1;
          idat   <= mem[iadr[11:2]];
          istall <= int'($urandom_range(max_stall, 0));
        end else istall <= istall - 1;
      end
      if (dcyc && dstb && !dack && !hold_dack) begin
        if (dstall == 0) begin
          dack   <= 1'b1;
          drdat  <= mem[dadr[11:2]];
          dstall <= int'($urandom_range(max_stall, 0));
          if (dwe) begin
            for (int b = 0; b < 4; b++)
              if (dsel[b]) mem[dadr[11:2]][8*b +: 8] <= dwdat[8*b +: 8];
            if (dsel != 4'hF) begin
              bw_sel <= dsel;
              bw_dat <= dwdat;
            end
          end
        end else dstall <= dstall - 1;
      end
    end
  end

  always @(negedge clk) if (icyc && dcyc) both_cyc <= both_cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] prog [12];
    int          nchk;
    int          idx  [3];
    logic [31:0] exp  [3];
    bit          bytewr;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_img(input int k);
    for (int i = 0; i < 1024; i++) img[i] = 32'd0;
    for (int i = 0; i < 12; i++) img[i] = vecs[k].prog[i];
    for (int i = 496; i < 504; i++) img[i] = 32'hDEAD_BEEF;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int k, input string tag);
    load_img(k);
    do_reset();
    repeat (600) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < vecs[k].nchk; c++)
      check($sformatf("%s_%s_w%0d", vecs[k].name, tag, vecs[k].idx[c]),
            128'(mem[vecs[k].idx[c]]), 128'(vecs[k].exp[c]));
    if (vecs[k].bytewr) begin
      check($sformatf("%s_%s_strb_sel", vecs[k].name, tag), 128'(bw_sel), 128'(4'b0010));
      check($sformatf("%s_%s_strb_dat", vecs[k].name, tag), 128'(bw_dat), 128'(32'hABAB_ABAB));
    end
  endtask

  initial begin
    bit found;

    vecs[0] = '{"mov_add_str",
      '{32'hE3A00005, 32'hE2801003, 32'hE58017C3, HALT, HALT, HALT,
        HALT, HALT, HALT, HALT, HALT, HALT},
      1, '{498, 0, 0}, '{32'h8, 32'h0, 32'h0}, 1'b0};
    vecs[1] = '{"cmp_cond",
      '{32'hE3A00005, 32'hE3A06D1F, 32'hE3500005, 32'h13A03001, 32'h03A04007, 32'h23A07009,
        32'hE5863000, 32'hE5864004, 32'hE5867008, HALT, HALT, HALT},
      3, '{496, 497, 498}, '{32'h0, 32'h7, 32'h9}, 1'b0};
    vecs[2] = '{"bl_skip",
      '{32'hE3A06D1F, 32'hEB000000, 32'hE3A02055, 32'hE586E000, 32'hE5862004, HALT,
        HALT, HALT, HALT, HALT, HALT, HALT},
      2, '{496, 497, 0}, '{32'h8, 32'h0, 32'h0}, 1'b0};
    vecs[3] = '{"strb_ldrb",
      '{32'hE3A05D1F, 32'hE2855009, 32'hE3A000AB, 32'hE5C50000, 32'hE5D51000, 32'hE3A06D1F,
        32'hE5861004, HALT, HALT, HALT, HALT, HALT},
      2, '{498, 497, 0}, '{32'hDEADABEF, 32'h0000_00AB, 32'h0}, 1'b1};
    vecs[4] = '{"shift_alu",
      '{32'hE3A06D1F, 32'hE3A00102, 32'hE1A01240, 32'hE1E02001, 32'hE0813082, 32'hE2624000,
        32'hE5861000, 32'hE5863004, 32'hE5864008, HALT, HALT, HALT},
      3, '{496, 497, 498}, '{32'hF800_0000, 32'h07FF_FFFE, 32'hF800_0001}, 1'b0};
    vecs[5] = '{"flags_adc_rrx",
      '{32'hE3A06D1F, 32'hE3A00102, 32'hE0901000, 32'hE2A12005, 32'hE1A03060, 32'h63A04003,
        32'hE5862000, 32'hE5863004, 32'hE5864008, HALT, HALT, HALT},
      3, '{496, 497, 498}, '{32'h6, 32'hC000_0000, 32'h3}, 1'b0};
    vecs[6] = '{"idx_writeback",
      '{32'hE3A06D1F, 32'hE3A00011, 32'hE4860004, 32'hE5A66004, 32'hE5066004, HALT,
        HALT, HALT, HALT, HALT, HALT, HALT},
      3, '{496, 497, 498}, '{32'h11, 32'h7C8, 32'h7C4}, 1'b0};

    load_img(0);
    #2 rst_n = 1'b0;
    #1 check("reset_bus_idle",
             128'({icyc, istb, iwe, isel, iadr, dcyc, dstb, dwe, dsel, dadr, dwdat}), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_fetch", 128'({icyc, istb, iwe, isel, iadr}), 128'({1'b1, 1'b1, 1'b0, 4'hF, 32'd0}));

    max_stall = 0;
    for (int k = 0; k < 7; k++) run_vec(k, "nostall");
    max_stall = 5;
    for (int k = 0; k < 7; k++) run_vec(k, "stall");
    max_stall = 0;
    check("no_bus_overlap", 128'(both_cyc), 128'(0));

    // Hold the data ack off so the store stays pending, then yank reset mid-cycle
    load_img(0);
    hold_dack = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (dcyc && dwe) found = 1'b1;
    end
    check("midreset_write_pending", 128'(found), 128'(1));
    #2 rst_n = 1'b0;
    #1 check("midreset_bus_drop", 128'({dcyc, dstb, dwe, dsel, icyc, istb}), 128'(0));
    hold_dack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_refetch", 128'({icyc, istb, iadr}), 128'({1'b1, 1'b1, 32'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
